// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pooling FSM states, output-size helper,
// default sample width.
package cnn_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST,
    FIN
  } maxpool_state_t;

  // Number of window positions along one axis.
  function automatic int unsigned pool_out_dim(input int unsigned fm,
                                               input int unsigned k,
                                               input int unsigned s);
    return (fm - k) / s + 1;
  endfunction

  // Bit width for a count of v items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/maxpool2d_mc_if.sv
// Control handshake plus feature-map read port and pooled-result write port
// of maxpool2d_mc. out_idx exists only when MAXPOOL_ARGMAX_EN is defined.
interface maxpool2d_mc_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned A_IN   = 14,
  parameter int unsigned A_OUT  = 12,
  parameter int unsigned IDX_W  = 2
) ();

  logic              start;
  logic              busy;
  logic              done;
  logic              fm_rd_en;
  logic [A_IN-1:0]   fm_rd_addr;
  logic [DATA_W-1:0] fm_rd_data;
  logic              out_we;
  logic [A_OUT-1:0]  out_addr;
  logic [DATA_W-1:0] out_data;
`ifdef MAXPOOL_ARGMAX_EN
  logic [IDX_W-1:0]  out_idx;
`endif

  modport master (
    input  start, fm_rd_data,
    output busy, done, fm_rd_en, fm_rd_addr, out_we, out_addr, out_data
`ifdef MAXPOOL_ARGMAX_EN
    , output out_idx
`endif
  );

  modport slave (
    output start, fm_rd_data,
    input  busy, done, fm_rd_en, fm_rd_addr, out_we, out_addr, out_data
`ifdef MAXPOOL_ARGMAX_EN
    , input out_idx
`endif
  );

endinterface

// File: rtl/maxpool2d_mc_addr_gen.sv
// maxpool_addr_gen: nested channel/orow/ocol/i/j counters producing the
// feature-map read address, pooled write address and window position flags.
module maxpool_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned FM_H     = 62,
  parameter int unsigned FM_W     = 62,
  parameter int unsigned KERNEL   = 2,
  parameter int unsigned STRIDE   = 2,
  parameter int unsigned A_IN     = 14,
  parameter int unsigned A_OUT    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             adv_elem,
  input  logic             adv_win,
  output logic [A_IN-1:0]  rd_addr,
  output logic [A_OUT-1:0] wr_addr,
  output logic             first_elem,
  output logic             last_elem,
  output logic             last_window
);

  localparam int unsigned OUT_H = pool_out_dim(FM_H, KERNEL, STRIDE);
  localparam int unsigned OUT_W = pool_out_dim(FM_W, KERNEL, STRIDE);
  localparam int unsigned CH_W  = clog2_min1(CHANNELS);
  localparam int unsigned OH_W  = clog2_min1(OUT_H);
  localparam int unsigned OW_W  = clog2_min1(OUT_W);
  localparam int unsigned K_W   = clog2_min1(KERNEL);

  logic [CH_W-1:0] ch_q;
  logic [OH_W-1:0] orow_q;
  logic [OW_W-1:0] ocol_q;
  logic [K_W-1:0]  i_q, j_q;
  logic            last_j, last_ocol, last_orow, last_ch;

  assign last_j    = (j_q == K_W'(KERNEL - 1));
  assign last_ocol = (ocol_q == OW_W'(OUT_W - 1));
  assign last_orow = (orow_q == OH_W'(OUT_H - 1));
  assign last_ch   = (ch_q == CH_W'(CHANNELS - 1));

  assign first_elem  = (i_q == '0) && (j_q == '0);
  assign last_elem   = (i_q == K_W'(KERNEL - 1)) && last_j;
  assign last_window = last_ch && last_orow && last_ocol;

  assign rd_addr = A_IN'(32'(ch_q) * (FM_H * FM_W)
                       + (32'(orow_q) * STRIDE + 32'(i_q)) * FM_W
                       + 32'(ocol_q) * STRIDE + 32'(j_q));
  assign wr_addr = A_OUT'(32'(ch_q) * (OUT_H * OUT_W)
                        + 32'(orow_q) * OUT_W + 32'(ocol_q));

  // Element counters step within a window; window counters step after its write.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch_q   <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (adv_win) begin
      i_q <= '0;
      j_q <= '0;
      if (last_ocol) begin
        ocol_q <= '0;
        if (last_orow) begin
          orow_q <= '0;
          ch_q   <= last_ch ? '0 : ch_q + CH_W'(1);
        end else begin
          orow_q <= orow_q + OH_W'(1);
        end
      end else begin
        ocol_q <= ocol_q + OW_W'(1);
      end
    end else if (adv_elem) begin
      if (last_j) begin
        j_q <= '0;
        i_q <= i_q + K_W'(1);
      end else begin
        j_q <= j_q + K_W'(1);
      end
    end
  end

endmodule

// File: rtl/maxpool2d_mc.sv
// maxpool2d_mc: multi-channel 2-D max-pooling engine. Reads each window through
// a one-cycle-latency read port, writes its signed maximum once per window.
// Define MAXPOOL_ARGMAX_EN to also track and output the argmax offset (out_idx).
module maxpool2d_mc
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned FM_H     = 62,
  parameter int unsigned FM_W     = 62,
  parameter int unsigned KERNEL   = 2,
  parameter int unsigned STRIDE   = 2
) (
  input logic            clk,
  input logic            rst,
  maxpool2d_mc_if.master bus
);

  localparam int unsigned OUT_H = pool_out_dim(FM_H, KERNEL, STRIDE);
  localparam int unsigned OUT_W = pool_out_dim(FM_W, KERNEL, STRIDE);
  localparam int unsigned A_IN  = clog2_min1(CHANNELS * FM_H * FM_W);
  localparam int unsigned A_OUT = clog2_min1(CHANNELS * OUT_H * OUT_W);

  maxpool_state_t state_q, state_d;
  logic rd_en, we, gen_clear, adv_elem, adv_win;
  logic [A_IN-1:0]  gen_rd_addr;
  logic [A_OUT-1:0] gen_wr_addr;
  logic first_elem, last_elem, last_window;

  maxpool_addr_gen #(
    .CHANNELS(CHANNELS), .FM_H(FM_H), .FM_W(FM_W),
    .KERNEL(KERNEL), .STRIDE(STRIDE), .A_IN(A_IN), .A_OUT(A_OUT)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .clear(gen_clear), .adv_elem(adv_elem), .adv_win(adv_win),
    .rd_addr(gen_rd_addr), .wr_addr(gen_wr_addr),
    .first_elem(first_elem), .last_elem(last_elem), .last_window(last_window)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and strobes: RUN issues one read per cycle, LAST writes the window.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    we        = 1'b0;
    gen_clear = 1'b0;
    adv_elem  = 1'b0;
    adv_win   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d   = RUN;
        gen_clear = 1'b1;
      end
      RUN: begin
        rd_en = 1'b1;
        if (last_elem) state_d = LAST;
        else           adv_elem = 1'b1;
      end
      LAST: begin
        we      = 1'b1;
        adv_win = 1'b1;
        state_d = last_window ? FIN : RUN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags its strobe by one cycle, so the window-position flag lags too.
  logic vld_q, first_q, take;
  logic signed [DATA_W-1:0] rd_data, max_q, win_max;

  assign rd_data = bus.fm_rd_data;
  assign take    = first_q || (rd_data > max_q);
  assign win_max = take ? rd_data : max_q;

  // Track which returning sample is the first of its window.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      vld_q   <= rd_en;
      first_q <= rd_en && first_elem;
    end
  end

  // Running maximum: first sample loads, later ones replace only if strictly greater.
  always_ff @(posedge clk) begin
    if (vld_q) max_q <= win_max;
  end

`ifdef MAXPOOL_ARGMAX_EN
  localparam int unsigned IDX_W = clog2_min1(KERNEL * KERNEL);
  logic [IDX_W-1:0] rd_idx_q, arg_q, win_arg;

  assign win_arg = take ? rd_idx_q : arg_q;

  // Raster offset of the sample returning this cycle.
  always_ff @(posedge clk) begin
    if (rst)        rd_idx_q <= '0;
    else if (rd_en) rd_idx_q <= first_elem ? '0 : rd_idx_q + IDX_W'(1);
  end

  // Argmax follows the same update decision as the maximum.
  always_ff @(posedge clk) begin
    if (vld_q) arg_q <= win_arg;
  end

  assign bus.out_idx = we ? win_arg : '0;
`endif

  assign bus.busy       = (state_q == RUN) || (state_q == LAST);
  assign bus.done       = (state_q == FIN);
  assign bus.fm_rd_en   = rd_en;
  assign bus.fm_rd_addr = rd_en ? gen_rd_addr : '0;
  assign bus.out_we     = we;
  assign bus.out_addr   = we ? gen_wr_addr : '0;
  assign bus.out_data   = we ? win_max : '0;

endmodule

// File: tb/tb_maxpool2d_mc.sv
// Directed bench for maxpool2d_mc on three geometries:
//   A: 1ch 4x4 K2 S2, B: 2ch 5x5 K2 S2, C: 1ch 5x5 K3 S1.
// out_idx checks are compiled only with MAXPOOL_ARGMAX_EN.
module tb_maxpool2d_mc;

  localparam int unsigned AI_A = cnn_pkg::clog2_min1(16);
  localparam int unsigned AO_A = cnn_pkg::clog2_min1(4);
  localparam int unsigned AI_B = cnn_pkg::clog2_min1(50);
  localparam int unsigned AO_B = cnn_pkg::clog2_min1(8);
  localparam int unsigned AI_C = cnn_pkg::clog2_min1(25);
  localparam int unsigned AO_C = cnn_pkg::clog2_min1(9);
  localparam int unsigned IX_A = cnn_pkg::clog2_min1(4);
  localparam int unsigned IX_C = cnn_pkg::clog2_min1(9);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool2d_mc_if #(.DATA_W(16), .A_IN(AI_A), .A_OUT(AO_A), .IDX_W(IX_A)) ifa ();
  maxpool2d_mc_if #(.DATA_W(16), .A_IN(AI_B), .A_OUT(AO_B), .IDX_W(IX_A)) ifb ();
  maxpool2d_mc_if #(.DATA_W(16), .A_IN(AI_C), .A_OUT(AO_C), .IDX_W(IX_C)) ifc ();

  maxpool2d_mc #(.DATA_W(16), .CHANNELS(1), .FM_H(4), .FM_W(4), .KERNEL(2), .STRIDE(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  maxpool2d_mc #(.DATA_W(16), .CHANNELS(2), .FM_H(5), .FM_W(5), .KERNEL(2), .STRIDE(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
  maxpool2d_mc #(.DATA_W(16), .CHANNELS(1), .FM_H(5), .FM_W(5), .KERNEL(3), .STRIDE(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.master));

  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [50];
  logic signed [15:0] mem_c [25];
  int reads_b = 0, bad_b = 0, reads_c = 0;

  // One-cycle-latency memories.
  always @(posedge clk) ifa.fm_rd_data <= ifa.fm_rd_en ? mem_a[ifa.fm_rd_addr] : '0;
  always @(posedge clk) begin
    ifb.fm_rd_data <= ifb.fm_rd_en ? mem_b[ifb.fm_rd_addr] : '0;
    if (ifb.fm_rd_en) begin
      reads_b++;
      if ((int'(ifb.fm_rd_addr) % 25) / 5 == 4 || (int'(ifb.fm_rd_addr) % 25) % 5 == 4) bad_b++;
    end
  end
  always @(posedge clk) begin
    ifc.fm_rd_data <= ifc.fm_rd_en ? mem_c[ifc.fm_rd_addr] : '0;
    if (ifc.fm_rd_en) reads_c++;
  end

  // Write monitors, sampled on the falling edge.
  int wa_n = 0, viol_a = 0, done_a = 0;
  int wa_cyc [16];
  logic [AO_A-1:0] wa_addr [16];
  logic signed [15:0] wa_data [16];
  logic [IX_A-1:0] wa_idx [16];
  always @(negedge clk) begin
    if (ifa.out_we) begin
      if (wa_n < 16) begin
        wa_cyc[wa_n] = cyc; wa_addr[wa_n] = ifa.out_addr; wa_data[wa_n] = ifa.out_data;
`ifdef MAXPOOL_ARGMAX_EN
        wa_idx[wa_n] = ifa.out_idx;
`else
        wa_idx[wa_n] = '0;
`endif
      end
      wa_n++;
    end else if (ifa.out_addr != '0 || ifa.out_data != '0) viol_a++;
    if (!ifa.fm_rd_en && ifa.fm_rd_addr != '0) viol_a++;
    if (ifa.done) done_a++;
  end

  int wb_n = 0;
  int wb_cyc [16];
  logic [AO_B-1:0] wb_addr [16];
  logic signed [15:0] wb_data [16];
  always @(negedge clk) begin
    if (ifb.out_we) begin
      if (wb_n < 16) begin
        wb_cyc[wb_n] = cyc; wb_addr[wb_n] = ifb.out_addr; wb_data[wb_n] = ifb.out_data;
      end
      wb_n++;
    end
  end

  int wc_n = 0;
  int wc_cyc [16];
  logic [AO_C-1:0] wc_addr [16];
  logic signed [15:0] wc_data [16];
  logic [IX_C-1:0] wc_idx [16];
  always @(negedge clk) begin
    if (ifc.out_we) begin
      if (wc_n < 16) begin
        wc_cyc[wc_n] = cyc; wc_addr[wc_n] = ifc.out_addr; wc_data[wc_n] = ifc.out_data;
`ifdef MAXPOOL_ARGMAX_EN
        wc_idx[wc_n] = ifc.out_idx;
`else
        wc_idx[wc_n] = '0;
`endif
      end
      wc_n++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
    n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifa.done); end
    n_checks++; if (ifa.fm_rd_en !== 1'b0 || ifa.fm_rd_addr !== '0) begin
      n_fail++; $display("FAIL reset_rd: en %b addr %0d want 0 0", ifa.fm_rd_en, ifa.fm_rd_addr); end
    n_checks++; if (ifa.out_we !== 1'b0 || ifa.out_addr !== '0 || ifa.out_data !== '0) begin
      n_fail++; $display("FAIL reset_wr: we %b addr %0d data %0d want 0", ifa.out_we, ifa.out_addr, ifa.out_data); end
    n_checks++; if (ifb.busy !== 1'b0 || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_bc: got %b %b want 0 0", ifb.busy, ifc.busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ifa.busy !== 1'b0 || ifa.fm_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy %b rd_en %b want 0 0", ifa.busy, ifa.fm_rd_en); end
  endtask

  // Runs one pass on A from idle and checks the four writes against the tables.
  task automatic run_a(input string tag, input logic signed [15:0] exp_d [4],
                       input logic [IX_A-1:0] exp_i [4], input bit poke_start);
    int t;
    @(negedge clk);
    wa_n = 0; viol_a = 0; t = cyc; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n_checks++; if (ifa.busy !== 1'b1 || ifa.fm_rd_en !== 1'b1 || ifa.fm_rd_addr !== '0) begin
      n_fail++; $display("FAIL %s_first_read: busy %b en %b addr %0d want 1 1 0", tag, ifa.busy, ifa.fm_rd_en, ifa.fm_rd_addr); end
    for (int k = 0; k < 100 && ifa.done !== 1'b1; k++) begin
      ifa.start = poke_start && (cyc == t + 8);
      @(negedge clk);
    end
    ifa.start = 1'b0;
    n_checks++; if (ifa.done !== 1'b1 || cyc !== t + 21) begin
      n_fail++; $display("FAIL %s_done: done %b at cycle t+%0d want 1 at t+21", tag, ifa.done, cyc - t); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done: got %b want 0", tag, ifa.busy); end
    n_checks++; if (wa_n !== 4) begin n_fail++; $display("FAIL %s_write_count: got %0d want 4", tag, wa_n); end
    n_checks++; if (viol_a !== 0) begin n_fail++; $display("FAIL %s_idle_bus_zero: got %0d nonzero cycles want 0", tag, viol_a); end
    for (int n = 0; n < 4; n++) begin
      n_checks++; if (wa_addr[n] !== AO_A'(n) || wa_data[n] !== exp_d[n] || wa_cyc[n] !== t + 5 + 5 * n) begin
        n_fail++; $display("FAIL %s_write%0d: addr %0d data %0d cycle t+%0d want %0d %0d t+%0d",
                           tag, n, wa_addr[n], wa_data[n], wa_cyc[n] - t, n, exp_d[n], 5 + 5 * n); end
`ifdef MAXPOOL_ARGMAX_EN
      n_checks++; if (wa_idx[n] !== exp_i[n]) begin
        n_fail++; $display("FAIL %s_idx%0d: got %0d want %0d", tag, n, wa_idx[n], exp_i[n]); end
`endif
    end
  endtask

  task automatic test_raster();
    logic signed [15:0] exp_d [4];
    logic [IX_A-1:0] exp_i [4];
    exp_d = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    exp_i = '{2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
    run_a("raster", exp_d, exp_i, 1'b1);
  endtask

  task automatic test_signed_ties();
    logic signed [15:0] exp_d [4];
    logic [IX_A-1:0] exp_i [4];
    exp_d = '{-16'sd3, 16'sd7, 16'sh8000, 16'sd32767};
    exp_i = '{2'd1, 2'd0, 2'd0, 2'd1};
    mem_a[0] = -16'sd5;   mem_a[1] = -16'sd3;   mem_a[4] = -16'sd9;   mem_a[5] = -16'sd4;
    mem_a[2] = 16'sd7;    mem_a[3] = 16'sd7;    mem_a[6] = 16'sd2;    mem_a[7] = 16'sd7;
    mem_a[8] = 16'sh8000; mem_a[9] = 16'sh8000; mem_a[12] = 16'sh8000; mem_a[13] = 16'sh8000;
    mem_a[10] = -16'sd1;  mem_a[11] = 16'sd32767; mem_a[14] = 16'sd32767; mem_a[15] = 16'sd0;
    run_a("signed", exp_d, exp_i, 1'b0);
  endtask

  task automatic test_multichannel();
    int t;
    logic signed [15:0] exp_d [8];
    exp_d = '{16'sd6, 16'sd8, 16'sd16, 16'sd18, 16'sd106, 16'sd108, 16'sd116, 16'sd118};
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          mem_b[ch * 25 + r * 5 + c] = (r < 4 && c < 4) ? 16'(ch * 100 + r * 5 + c) : 16'sd1000;
    @(negedge clk);
    wb_n = 0; reads_b = 0; bad_b = 0; t = cyc; ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    for (int k = 0; k < 200 && ifb.done !== 1'b1; k++) @(negedge clk);
    n_checks++; if (ifb.done !== 1'b1 || cyc !== t + 41) begin
      n_fail++; $display("FAIL mc_done: done %b at cycle t+%0d want 1 at t+41", ifb.done, cyc - t); end
    n_checks++; if (wb_n !== 8) begin n_fail++; $display("FAIL mc_write_count: got %0d want 8", wb_n); end
    n_checks++; if (reads_b !== 32 || bad_b !== 0) begin
      n_fail++; $display("FAIL mc_reads: total %0d uncovered %0d want 32 0", reads_b, bad_b); end
    for (int n = 0; n < 8; n++) begin
      n_checks++; if (wb_addr[n] !== AO_B'(n) || wb_data[n] !== exp_d[n] || wb_cyc[n] !== t + 5 + 5 * n) begin
        n_fail++; $display("FAIL mc_write%0d: addr %0d data %0d cycle t+%0d want %0d %0d t+%0d",
                           n, wb_addr[n], wb_data[n], wb_cyc[n] - t, n, exp_d[n], 5 + 5 * n); end
    end
  endtask

  task automatic test_reset_abort();
    int t;
    int d0;
    logic signed [15:0] exp_d [4];
    logic [IX_A-1:0] exp_i [4];
    exp_d = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    exp_i = '{2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
    @(negedge clk);
    wa_n = 0; t = cyc; d0 = done_a; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    while (cyc < t + 17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.fm_rd_en !== 1'b0 || ifa.out_we !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy %b done %b rd_en %b we %b want 0 0 0 0",
                         ifa.busy, ifa.done, ifa.fm_rd_en, ifa.out_we); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (wa_n !== 3 || done_a !== d0) begin
      n_fail++; $display("FAIL abort_no_more_writes: writes %0d dones %0d want 3 0", wa_n, done_a - d0); end
    run_a("restart", exp_d, exp_i, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t;
    logic signed [15:0] exp_d [9];
    exp_d = '{16'sd24, 16'sd23, 16'sd22, 16'sd19, 16'sd18, 16'sd17, 16'sd14, 16'sd13, 16'sd12};
    for (int i = 0; i < 25; i++) mem_c[i] = 16'(24 - i);
    @(negedge clk);
    wc_n = 0; reads_c = 0; t = cyc; ifc.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 300 && ifc.done !== 1'b1; k++) @(negedge clk);
    n_checks++; if (ifc.done !== 1'b1 || cyc !== t + 91 || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: done %b busy %b at cycle t+%0d want 1 0 at t+91", ifc.done, ifc.busy, cyc - t); end
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (wc_n !== 9 || reads_c !== 81 || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_single_pass: writes %0d reads %0d busy %b want 9 81 0", wc_n, reads_c, ifc.busy); end
    for (int n = 0; n < 9; n++) begin
      n_checks++; if (wc_addr[n] !== AO_C'(n) || wc_data[n] !== exp_d[n] || wc_cyc[n] !== t + 10 + 10 * n) begin
        n_fail++; $display("FAIL b2b_write%0d: addr %0d data %0d cycle t+%0d want %0d %0d t+%0d",
                           n, wc_addr[n], wc_data[n], wc_cyc[n] - t, n, exp_d[n], 10 + 10 * n); end
`ifdef MAXPOOL_ARGMAX_EN
      n_checks++; if (wc_idx[n] !== '0) begin n_fail++; $display("FAIL b2b_idx%0d: got %0d want 0", n, wc_idx[n]); end
`endif
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
    test_reset();
    test_raster();
    test_signed_ties();
    test_multichannel();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/maxpool2d_mc.md
# maxpool2d_mc

Multi-channel, parametrised 2-D max-pooling engine for the CNN forward datapath, placed between the Conv2d output buffer and the next layer's input buffer. It reads a channel-planar feature map through a one-cycle-latency memory read port and writes one pooled value per window through a write port. Comparison is signed. The per-window argmax index can optionally be written out for the backward pass.

## Interface
- DATA_W, 16, sample width, two's complement
- CHANNELS, 4, number of feature-map planes
- FM_H, 62, input height
- FM_W, 62, input width
- KERNEL, 2, square window size, ≥1
- STRIDE, 2, window step, ≥1
- Derived (localparam): OUT_H=(FM_H-KERNEL)/STRIDE+1; OUT_W likewise; IDX_W=$clog2(KERNEL*KERNEL), minimum 1; addresses are sized with $clog2 of the plane totals.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin one full pooling pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write
- fm_rd_en  out  1  read strobe
- fm_rd_addr  out  A_IN  address = ch*FM_H*FM_W + r*FM_W + c
- fm_rd_data  in  DATA_W  valid exactly one cycle after fm_rd_en
- out_we  out  1  write strobe, one per window
- out_addr  out  A_OUT  address = ch*OUT_H*OUT_W + orow*OUT_W + ocol
- out_data  out  DATA_W  window maximum
- out_idx  out  IDX_W  argmax within the window, raster offset i*KERNEL+j (only with MAXPOOL_ARGMAX_EN)

## Operation
- FSM states: IDLE, RUN, LAST, FIN.
  - IDLE→RUN: on start.
  - RUN: issues KERNEL*KERNEL reads, one per cycle, in the order i outer and j inner.
  - LAST: the final read's data is compared and out_we is asserted with the result. It then goes to RUN for the next window, or to FIN after the final window.
  - FIN: pulses done, then returns to IDLE.
- Loop order: channel (outermost), orow, ocol, i, j (innermost).
- Max register: the first element of each window loads unconditionally; it is never initialised to 0, so all-negative windows pool correctly.
- Update uses strict >. On ties the earliest element in raster order wins, together with its index.
- start is ignored while busy. A start asserted in the same cycle as the done pulse is ignored.
- Rows/columns not covered by any window (non-divisible sizes) are never read.
- All outputs drive 0 when not strobed: fm_rd_addr, out_addr, out_data and out_idx hold 0 outside their strobe cycles.
- rst at any time aborts the pass.
  - Next cycle: IDLE, busy=0, done=0, no strobes.
  - Partial window results are discarded.

## Timing
- start accepted at edge t: busy=1 and first fm_rd_en in cycle t+1.
- Window period P = KERNEL*KERNEL+1 cycles: KERNEL*KERNEL read cycles plus one write cycle.
- Window n (global index across channels) writes in cycle t+1+n*P+KERNEL*KERNEL.
  - The write cycle overlaps no read.
  - The next window's first read is in the following cycle.
- done is in cycle t+1+N*P, with N=CHANNELS*OUT_H*OUT_W. busy falls in that same cycle.
- Reset values: busy=0, done=0, fm_rd_en=0, out_we=0, all buses 0.

## Configuration
- MAXPOOL_ARGMAX_EN defined:
  - out_idx port exists.
  - The argmax register tracks the winning offset.
  - out_idx is valid with out_we.
- MAXPOOL_ARGMAX_EN undefined:
  - Port and register are removed.
  - All other timing is identical.

## Structure
- Shared package cnn_pkg:
  - state enum maxpool_state_t;
  - the OUT_H/OUT_W computation function;
  - the default DATA_W.
- One sub-module, maxpool_addr_gen: the nested channel/orow/ocol/i/j counters. It exposes read address, write address, first_elem, last_elem and last_window flags.
- The top level holds the FSM, the compare/max register and the argmax register.

## Test plan
- 1 channel, 4x4 map with values 0..15 raster, K=S=2 → writes 5,7,13,15 to addr 0..3; done at t+1+4*5=t+21.
- Window {-5,-3,-9,-4} → out_data=-3 (not 0); out_idx=1.
- Tie window {7,7,2,7} → out_data=7, out_idx=0.
- 5x5 map, K=2, S=2, 2 channels → 8 writes, channel-1 addresses 4..7; row/col 4 never read.
- rst asserted mid-window 3 → next cycle busy=0 and no further out_we. A fresh start recomputes all windows from window 0.
- start held high through done → exactly one pass; with K=3, S=1 on 5x5, 9 writes, P=10.
